// File: rtl/interrupt_control_unit_pkg.sv
// Shared definitions for the interrupt control unit: ALU codes, FSM state encoding, vector default.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package interrupt_control_unit_pkg;

    // ALU function codes the ICU drives while it owns the control bundle.
    localparam logic [3:0] ALU_PASS_OP2 = 4'b0100;
    localparam logic [3:0] ALU_NOP      = 4'b0000;

    // Data-memory address of the ISR vector high word; low word follows it.
    localparam int INT_VEC_ADDR = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_PUSH_HI  = 3'd2,
        ST_PUSH_LO  = 3'd3,
        ST_PUSH_FLG = 3'd4,
        ST_RD_HI    = 3'd5,
        ST_RD_LO    = 3'd6,
        ST_JUMP     = 3'd7
    } icu_state_e;

    function automatic logic is_push_state(input icu_state_e s);
        return (s == ST_PUSH_HI) || (s == ST_PUSH_LO) || (s == ST_PUSH_FLG);
    endfunction

endpackage

// File: rtl/int_pending_latch.sv
// Rising-edge detector on the interrupt request with a one-deep pending flag.
// Latency: pending rises on the clock edge that samples the 0->1 transition of i_req.
// Backpressure: none; a new edge coinciding with i_clr keeps the flag set, extra edges merge.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_req        raw interrupt request level
//   i_clr        consume the pending request (FSM leaves IDLE)
//   o_pending    a request is waiting to be serviced
module int_pending_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic i_clr,
    output logic o_pending
);

    logic r_req_d;
    logic r_pending;
    logic w_edge;

    assign w_edge    = i_req & ~r_req_d;
    assign o_pending = r_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_d   <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_req_d   <= i_req;
            // Set dominates clear so an edge landing on the consume cycle is not lost.
            r_pending <= w_edge | (r_pending & ~i_clr);
        end
    end

endmodule

// File: rtl/interrupt_control_unit.sv
// Interrupt controller: freezes fetch, drains, pushes PC/flags, fetches the ISR vector, branches.
// Latency: JUMP is reached 6+DRAIN_CYCLES cycles after the request edge is sampled (no stalls).
// Backpressure: i_stall holds state and captured data and suppresses all side-effect strobes.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_int_req           interrupt request (rising edge = request)
//   i_stall             pipeline/memory stall
//   i_pc_in             PC of the next unexecuted instruction
//   i_flags_in          condition flags {C,N,Z}
//   i_mem_rdata         data-memory read data, valid the cycle after o_dmr
//   o_int_flag          ICU owns the decode control bundle
//   o_freeze_fetch      hold PC/fetch, inject NOPs
//   o_stack_operation   address memory via SP
//   o_push_pop          1 = push
//   o_write_sp          SP update strobe
//   o_dmw / o_dmr       data-memory write / read strobes
//   o_alu_function      pass-operand-2 during pushes
//   o_push_data         word written on push
//   o_mem_addr          vector address (valid with o_dmr)
//   o_branch            one-cycle redirect strobe
//   o_target_pc         ISR address (valid with o_branch)
//   o_int_ack           one-cycle dispatch pulse
module interrupt_control_unit
    import interrupt_control_unit_pkg::*;
#(
    parameter int PC_WIDTH     = 32,
    parameter int DATA_WIDTH   = 16,
    parameter int FLAG_WIDTH   = 3,
    parameter int DRAIN_CYCLES = 3,
    parameter int VEC_ADDR     = INT_VEC_ADDR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_int_req,
    input  logic                  i_stall,
    input  logic [PC_WIDTH-1:0]   i_pc_in,
    input  logic [FLAG_WIDTH-1:0] i_flags_in,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_int_flag,
    output logic                  o_freeze_fetch,
    output logic                  o_stack_operation,
    output logic                  o_push_pop,
    output logic                  o_write_sp,
    output logic                  o_dmw,
    output logic                  o_dmr,
    output logic [3:0]            o_alu_function,
    output logic [DATA_WIDTH-1:0] o_push_data,
    output logic [PC_WIDTH-1:0]   o_mem_addr,
    output logic                  o_branch,
    output logic [PC_WIDTH-1:0]   o_target_pc,
    output logic                  o_int_ack
);

    localparam logic [2:0] LP_CNT_INIT = 3'(DRAIN_CYCLES - 1);

    icu_state_e            r_state;
    icu_state_e            w_state_nxt;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_nxt;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [FLAG_WIDTH-1:0] r_flags;
    logic [DATA_WIDTH-1:0] r_vec_hi;
    logic                  w_pending;
    logic                  w_pend_clr;
    logic                  w_run;
    logic                  w_take;

    assign w_run  = ~i_stall;
    assign w_take = w_run && (r_state == ST_IDLE) && w_pending;

    int_pending_latch u_pending (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_int_req),
        .i_clr     (w_pend_clr),
        .o_pending (w_pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 3'd0;
            r_pc     <= '0;
            r_flags  <= '0;
            r_vec_hi <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_take) begin
                r_pc    <= i_pc_in;
                r_flags <= i_flags_in;
            end
            // Read data for the RD_HI access is on the bus during RD_LO; a stalled
            // memory keeps it there, so only the unstalled cycle captures it.
            if (w_run && (r_state == ST_RD_LO)) begin
                r_vec_hi <= i_mem_rdata;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_clr  = 1'b0;
        if (w_run) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pending) begin
                        w_state_nxt = ST_DRAIN;
                        w_cnt_nxt   = LP_CNT_INIT;
                        w_pend_clr  = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == 3'd0) begin
                        w_state_nxt = ST_PUSH_HI;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
                ST_PUSH_HI:  w_state_nxt = ST_PUSH_LO;
                ST_PUSH_LO:  w_state_nxt = ST_PUSH_FLG;
                ST_PUSH_FLG: w_state_nxt = ST_RD_HI;
                ST_RD_HI:    w_state_nxt = ST_RD_LO;
                ST_RD_LO:    w_state_nxt = ST_JUMP;
                ST_JUMP:     w_state_nxt = ST_IDLE;
                default:     w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs decode from the registered state so an asynchronous reset clears
    // them in the same cycle. Strobes with side effects are masked by stall.
    always_comb begin
        o_int_flag        = (r_state != ST_IDLE);
        o_freeze_fetch    = (r_state != ST_IDLE);
        o_stack_operation = 1'b0;
        o_push_pop        = 1'b0;
        o_write_sp        = 1'b0;
        o_dmw             = 1'b0;
        o_dmr             = 1'b0;
        o_alu_function    = ALU_NOP;
        o_push_data       = '0;
        o_mem_addr        = '0;
        o_branch          = 1'b0;
        o_target_pc       = '0;
        o_int_ack         = 1'b0;

        if (is_push_state(r_state)) begin
            o_stack_operation = 1'b1;
            o_push_pop        = 1'b1;
            o_write_sp        = w_run;
            o_dmw             = w_run;
            o_alu_function    = ALU_PASS_OP2;
        end

        case (r_state)
            ST_PUSH_HI:  o_push_data = r_pc[PC_WIDTH-1:DATA_WIDTH];
            ST_PUSH_LO:  o_push_data = r_pc[DATA_WIDTH-1:0];
            ST_PUSH_FLG: o_push_data = DATA_WIDTH'(r_flags);
            ST_RD_HI: begin
                o_dmr      = w_run;
                o_mem_addr = PC_WIDTH'(VEC_ADDR);
            end
            ST_RD_LO: begin
                o_dmr      = w_run;
                o_mem_addr = PC_WIDTH'(VEC_ADDR + 1);
            end
            ST_JUMP: begin
                o_branch    = w_run;
                o_int_ack   = w_run;
                o_target_pc = {r_vec_hi, i_mem_rdata};
            end
            default: ;
        endcase
    end

endmodule
